// File: rtl/lsu_dccm_req.sv
// LSU request sequencer for the DCCM: loads (including word-crossing), word stores, and
// read-modify-write sub-word stores, the latter only when RV_DCCM_RMW_EN is defined.
module lsu_dccm_req #(
    parameter int unsigned DCCM_BITS      = 16,
    parameter int unsigned DCCM_BANK_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 lsu_freeze_dc3,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic [DCCM_BITS-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 dccm_rden,
    output logic                 dccm_wren,
    output logic [DCCM_BITS-1:0] dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0] dccm_rd_addr_hi,
    output logic [DCCM_BITS-1:0] dccm_wr_addr,
    output logic [31:0]          dccm_wr_data,
    input  logic [31:0]          dccm_rd_data_lo,
    input  logic [31:0]          dccm_rd_data_hi
);

    if (DCCM_BITS < DCCM_BANK_BITS + 3) begin : g_cfg_check
        $error("DCCM_BITS too narrow for the bank-select field");
    end

    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR} state_t;

    state_t               r_state, w_next;
    logic [1:0]           r_off, r_size;
    logic                 r_cross, r_ack_vld, r_ack_err;
    logic                 w_ready, w_accept, w_cross, w_err_req;
    logic                 w_cap, w_ack_set, w_ack_err;
    logic [3:0]           w_end;
    logic [DCCM_BITS-3:0] w_hi_word;
    logic [63:0]          w_ld_src;
    logic [31:0]          w_ld_word, w_ld_data;

    assign w_ready   = rst_l & ~lsu_freeze_dc3 & ((r_state == IDLE) | (r_state == RD_WAIT));
    assign w_accept  = req_valid & w_ready;
    assign req_ready = w_ready;

    assign w_end     = {2'b00, req_addr[1:0]} + (4'd1 << req_size);
    assign w_cross   = w_end > 4'd4;
    assign w_hi_word = req_addr[DCCM_BITS-1:2] + 1'b1;

`ifdef RV_DCCM_RMW_EN
    assign w_err_req = (req_size == 2'd3) | (req_store & w_cross);
`else
    assign w_err_req = (req_size == 2'd3) | (req_store & (w_cross | (req_size != 2'd2)));
`endif

    assign w_ld_src  = r_cross ? {dccm_rd_data_hi, dccm_rd_data_lo} : {32'h0, dccm_rd_data_lo};
    assign w_ld_word = 32'(w_ld_src >> {r_off, 3'b000});

    always_comb begin
        case (r_size)
            2'd0:    w_ld_data = {24'h0, w_ld_word[7:0]};
            2'd1:    w_ld_data = {16'h0, w_ld_word[15:0]};
            default: w_ld_data = w_ld_word;
        endcase
    end

`ifdef RV_DCCM_RMW_EN
    logic [DCCM_BITS-3:0] r_word;
    logic [31:0]          r_wdata, w_mask, w_merged;

    assign w_mask   = (r_size == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << {r_off, 3'b000};
    assign w_merged = (dccm_rd_data_lo & ~w_mask) | ((r_wdata << {r_off, 3'b000}) & w_mask);
`endif

    always_comb begin
        w_next          = r_state;
        w_cap           = 1'b0;
        w_ack_set       = 1'b0;
        w_ack_err       = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wren       = 1'b0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wr_addr    = '0;
        dccm_wr_data    = '0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        rsp_err         = 1'b0;

        case (r_state)
            RD_WAIT: if (!lsu_freeze_dc3) begin
                rsp_valid = 1'b1;
                rsp_data  = w_ld_data;
                w_next    = IDLE;
            end
`ifdef RV_DCCM_RMW_EN
            // RMW_RD issues the word read; RMW_WR merges into the returned lo word and writes it.
            RMW_RD: if (!lsu_freeze_dc3) begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = {r_word, 2'b00};
                dccm_rd_addr_hi = {r_word, 2'b00};
                w_next          = RMW_WR;
            end
            RMW_WR: if (!lsu_freeze_dc3) begin
                dccm_wren    = 1'b1;
                dccm_wr_addr = {r_word, 2'b00};
                dccm_wr_data = w_merged;
                w_ack_set    = 1'b1;
                w_next       = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase

        if (r_ack_vld && !lsu_freeze_dc3) begin
            rsp_valid = 1'b1;
            rsp_err   = r_ack_err;
        end

        if (w_accept) begin
            if (w_err_req) begin
                w_ack_set = 1'b1;
                w_ack_err = 1'b1;
                w_next    = IDLE;
            end else if (!req_store) begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = req_addr;
                dccm_rd_addr_hi = w_cross ? {w_hi_word, 2'b00} : req_addr;
                w_cap           = 1'b1;
                w_next          = RD_WAIT;
            end else if (req_size == 2'd2) begin
                dccm_wren    = 1'b1;
                dccm_wr_addr = req_addr;
                dccm_wr_data = req_wdata;
                w_ack_set    = 1'b1;
                w_next       = IDLE;
            end
`ifdef RV_DCCM_RMW_EN
            else begin
                w_cap  = 1'b1;
                w_next = RMW_RD;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_size    <= '0;
            r_cross   <= 1'b0;
            r_ack_vld <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ack_vld <= w_ack_set | (r_ack_vld & lsu_freeze_dc3);
            if (w_ack_set) r_ack_err <= w_ack_err;
            if (w_cap) begin
                r_off   <= req_addr[1:0];
                r_size  <= req_size;
                r_cross <= w_cross;
            end
        end
    end

`ifdef RV_DCCM_RMW_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_word  <= '0;
            r_wdata <= '0;
        end else if (w_cap) begin
            r_word  <= req_addr[DCCM_BITS-1:2];
            r_wdata <= req_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dccm_req.sv
// Bench for lsu_dccm_req: directed scenarios plus randomized traffic checked against a
// byte-addressed memory model with an in-order expected-response queue.
module tb_lsu_dccm_req;

`ifdef RV_DCCM_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_l = 1'b0, lsu_freeze_dc3 = 1'b0;
    logic        req_valid = 1'b1, req_ready, req_store = 1'b0;
    logic [1:0]  req_size = 2'd2;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_err, dccm_rden, dccm_wren;
    logic [31:0] rsp_data, dccm_wr_data, dccm_rd_data_lo, dccm_rd_data_hi;
    logic [15:0] dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct { logic [31:0] data; logic err; int due; } exp_t;
    exp_t q[$];

    logic [31:0] mem [0:16383];
    logic [7:0]  ref_b [0:65535];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_dccm_req #(.DCCM_BITS(16), .DCCM_BANK_BITS(3)) dut (
        .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(lsu_freeze_dc3),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
        .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
        .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
        .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi)
    );

    // DCCM stub: one-cycle read latency, read data held until the next read.
    always @(posedge clk) begin
        if (dccm_wren) mem[dccm_wr_addr[15:2]] = dccm_wr_data;
        if (dccm_rden) begin
            dccm_rd_data_lo <= mem[dccm_rd_addr_lo[15:2]];
            dccm_rd_data_hi <= mem[dccm_rd_addr_hi[15:2]];
        end
    end

    task automatic set_word(input logic [15:0] a, input logic [31:0] v);
        mem[a[15:2]] = v;
        for (int i = 0; i < 4; i++) ref_b[{a[15:2], 2'b00} + 16'(i)] = v[8*i +: 8];
    endtask

    task automatic init_mem();
        for (int w = 0; w < 16384; w++) set_word(16'(w * 4), $urandom);
    endtask

    task automatic drive(input logic v, input logic st, input logic [1:0] sz,
                         input logic [15:0] a, input logic [31:0] wd);
        req_valid = v; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
        checks++; if ({dccm_rden, dccm_wren} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {dccm_rden, dccm_wren}); end
        @(posedge clk); #1;
        rst_l = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", req_ready); end
        next_cycle();
    endtask

    task automatic test_store_load();
        drive(1, 1, 2'd2, 16'h0010, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if ({dccm_wren, dccm_rden} !== 2'b10) begin errors++; $display("FAIL st_strobes got %b exp 10", {dccm_wren, dccm_rden}); end
        checks++; if ({dccm_wr_addr, dccm_wr_data} !== {16'h0010, 32'hDEADBEEF}) begin errors++; $display("FAIL st_wr got %h/%h exp 0010/deadbeef", dccm_wr_addr, dccm_wr_data); end
        next_cycle();
        drive(1, 0, 2'd2, 16'h0010, 32'h0);
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL st_ack got %b exp 10", {rsp_valid, rsp_err}); end
        checks++; if ({dccm_rden, dccm_rd_addr_lo, dccm_rd_addr_hi} !== {1'b1, 16'h0010, 16'h0010}) begin errors++; $display("FAIL ld_rd got %b %h %h exp 1 0010 0010", dccm_rden, dccm_rd_addr_lo, dccm_rd_addr_hi); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL ld_rsp got %b%b %h exp 10 deadbeef", rsp_valid, rsp_err, rsp_data); end
        next_cycle();
    endtask

    task automatic test_cross_load();
        set_word(16'h0014, 32'h44332211);
        set_word(16'h0018, 32'h88776655);
        drive(1, 0, 2'd1, 16'h0017, 32'h0);
        @(negedge clk);
        checks++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {16'h0017, 16'h0018}) begin errors++; $display("FAIL half_x_addr got %h %h exp 0017 0018", dccm_rd_addr_lo, dccm_rd_addr_hi); end
        next_cycle();
        set_word(16'hFFFC, 32'hAABBCCDD);
        set_word(16'h0000, 32'h11223344);
        drive(1, 0, 2'd2, 16'hFFFE, 32'h0);
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h00005544}) begin errors++; $display("FAIL half_x_data got %b %h exp 1 00005544", rsp_valid, rsp_data); end
        checks++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {16'hFFFE, 16'h0000}) begin errors++; $display("FAIL wrap_addr got %h %h exp fffe 0000", dccm_rd_addr_lo, dccm_rd_addr_hi); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h3344AABB}) begin errors++; $display("FAIL wrap_data got %b %h exp 1 3344aabb", rsp_valid, rsp_data); end
        next_cycle();
    endtask

    task automatic test_freeze();
        set_word(16'h0020, 32'hCAFEF00D);
        drive(1, 0, 2'd0, 16'h0021, 32'h0);
        @(negedge clk);
        checks++; if ({req_ready, dccm_rden} !== 2'b11) begin errors++; $display("FAIL frz_accept got %b exp 11", {req_ready, dccm_rden}); end
        next_cycle();
        lsu_freeze_dc3 = 1'b1;
        drive(1, 0, 2'd2, 16'h0024, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({rsp_valid, req_ready, dccm_rden, dccm_wren} !== 4'b0000) begin errors++; $display("FAIL frz_hold%0d got %b exp 0000", i, {rsp_valid, req_ready, dccm_rden, dccm_wren}); end
            next_cycle();
        end
        lsu_freeze_dc3 = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h000000F0}) begin errors++; $display("FAIL frz_rsp got %b%b %h exp 10 000000f0", rsp_valid, rsp_err, rsp_data); end
        next_cycle();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL frz_pulse got %b exp 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_errors();
        drive(1, 1, 2'd2, 16'h0002, 32'h12345678);
        @(negedge clk);
        checks++; if ({req_ready, dccm_rden, dccm_wren} !== 3'b100) begin errors++; $display("FAIL xst_strobes got %b exp 100", {req_ready, dccm_rden, dccm_wren}); end
        next_cycle();
        drive(1, 0, 2'd3, 16'h0004, 32'h0);
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin errors++; $display("FAIL xst_rsp got %b%b %h exp 11 0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (dccm_rden !== 1'b0) begin errors++; $display("FAIL sz3_rden got %b exp 0", dccm_rden); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("FAIL sz3_rsp got %b exp 11", {rsp_valid, rsp_err}); end
        next_cycle();
    endtask

`ifdef RV_DCCM_RMW_EN
    task automatic test_rmw();
        set_word(16'h0010, 32'h11223344);
        drive(1, 1, 2'd0, 16'h0013, 32'h000000A5);
        @(negedge clk);
        checks++; if ({req_ready, dccm_rden, dccm_wren} !== 3'b100) begin errors++; $display("FAIL rmw_acc got %b exp 100", {req_ready, dccm_rden, dccm_wren}); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi} !== {2'b10, 16'h0010, 16'h0010}) begin errors++; $display("FAIL rmw_rd got %b%b %h %h exp 10 0010 0010", dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi); end
        next_cycle();
        @(negedge clk);
        checks++; if ({dccm_rden, dccm_wren, dccm_wr_addr, dccm_wr_data} !== {2'b01, 16'h0010, 32'hA5223344}) begin errors++; $display("FAIL rmw_wr got %b%b %h %h exp 01 0010 a5223344", dccm_rden, dccm_wren, dccm_wr_addr, dccm_wr_data); end
        next_cycle();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL rmw_rsp got %b exp 10", {rsp_valid, rsp_err}); end
        next_cycle();
    endtask

    task automatic test_reset_mid_rmw();
        set_word(16'h0030, 32'h01020304);
        drive(1, 1, 2'd1, 16'h0031, 32'h00007777);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk); #1;
        rst_l = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_l = 1'b1;
            @(negedge clk);
            checks++; if ({rsp_valid, dccm_wren} !== 2'b00) begin errors++; $display("FAIL rstrmw%0d got %b exp 00", i, {rsp_valid, dccm_wren}); end
            next_cycle();
        end
        checks++; if (mem[12] !== 32'h01020304) begin errors++; $display("FAIL rstrmw_mem got %h exp 01020304", mem[12]); end
    endtask
`else
    task automatic test_sub_store_err();
        set_word(16'h0010, 32'h11223344);
        drive(1, 1, 2'd0, 16'h0013, 32'h000000A5);
        @(negedge clk);
        checks++; if ({req_ready, dccm_rden, dccm_wren} !== 3'b100) begin errors++; $display("FAIL bst_acc got %b exp 100", {req_ready, dccm_rden, dccm_wren}); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_err, dccm_rden, dccm_wren} !== 4'b1100) begin errors++; $display("FAIL bst_rsp got %b exp 1100", {rsp_valid, rsp_err, dccm_rden, dccm_wren}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({rsp_valid, dccm_rden, dccm_wren} !== 3'b000) begin errors++; $display("FAIL bst_idle got %b exp 000", {rsp_valid, dccm_rden, dccm_wren}); end
        checks++; if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL bst_mem got %h exp 11223344", mem[4]); end
        next_cycle();
    endtask
`endif

    task automatic test_random();
        exp_t e;
        int unsigned len;
        logic [15:0] ba;
        init_mem();
        for (int c = 0; c < 3000; c++) begin
            if (c < 2950) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_store = 1'($urandom_range(0, 1));
                req_size  = 2'($urandom_range(0, 3));
                req_addr  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                        : 16'($urandom_range(0, 63));
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            checks++; if (dccm_rden && dccm_wren) begin errors++; $display("FAIL rnd_both_strobes cyc %0d got 11 exp not both", cyc); end
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc %0d got rsp %h exp none", cyc, rsp_data);
                end else begin
                    e = q.pop_front();
                    if ({rsp_err, rsp_data} !== {e.err, e.data} || cyc != e.due) begin
                        errors++;
                        $display("FAIL rnd_rsp got err=%b data=%h cyc=%0d exp err=%b data=%h cyc=%0d", rsp_err, rsp_data, cyc, e.err, e.data, e.due);
                    end
                end
            end
            if (q.size() > 0) begin
                checks++;
                if (q[0].due < cyc) begin
                    errors++; $display("FAIL rnd_missing got none exp rsp at cyc %0d", q[0].due);
                    void'(q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                len    = 32'd1 << req_size;
                e.err  = (req_size == 2'd3) ||
                         (req_store && ((req_addr[1:0] + len > 4) || (req_size != 2'd2 && !RMW_EN)));
                e.data = '0;
                e.due  = cyc + 1;
                if (!e.err) begin
                    for (int unsigned i = 0; i < len; i++) begin
                        ba = req_addr + 16'(i);
                        if (req_store) ref_b[ba] = req_wdata[8*i +: 8];
                        else           e.data[8*i +: 8] = ref_b[ba];
                    end
                    if (req_store && req_size != 2'd2) e.due = cyc + 3;
                end
                q.push_back(e);
            end
            next_cycle();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_store_load();
        test_cross_load();
        test_freeze();
        test_errors();
`ifdef RV_DCCM_RMW_EN
        test_rmw();
        test_reset_mid_rmw();
`else
        test_sub_store_err();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dccm_req.md
LSU_DCCM_REQ -- requirements
Module: lsu_dccm_req

Interface
REQ-001 SHALL have parameter DCCM_BITS, default 16, DCCM byte-address width.
REQ-002 SHALL have parameter DCCM_BANK_BITS, default 3, bank-select width at address bit 2 upward.
REQ-003 SHALL have ports clk (in, 1, single clock) and rst_l (in, 1, reset; asynchronous, active-low).
REQ-004 SHALL have port lsu_freeze_dc3 (in, 1): pipeline freeze; DCCM holds its read data while high.
REQ-005 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_store (in, 1), req_size (in, 2: 0 byte, 1 half, 2 word), req_addr (in, DCCM_BITS), req_wdata (in, 32).
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_data (out, 32, load data zero-extended), rsp_err (out, 1).
REQ-007 SHALL have DCCM-side ports dccm_rden, dccm_wren (out, 1), dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr (out, DCCM_BITS), dccm_wr_data (out, 32), dccm_rd_data_lo, dccm_rd_data_hi (in, 32).

Function
REQ-008 SHALL run FSM states IDLE, RD_WAIT, RMW_RD, RMW_WR.
REQ-009 req_ready SHALL be ~lsu_freeze_dc3 & (state==IDLE | state==RD_WAIT); accept = req_valid & req_ready.
REQ-010 Crossing SHALL mean req_addr[1:0] + (1<<req_size) > 4; req_size==3 SHALL be treated as error.
REQ-011 Accepted load SHALL assert dccm_rden same cycle; rd_addr_lo = req_addr; rd_addr_hi = {req_addr[DCCM_BITS-1:2]+1, 2'b00} (wraps modulo 2^DCCM_BITS) if crossing, else req_addr; next state RD_WAIT.
REQ-012 In RD_WAIT without freeze: rsp_valid=1, rsp_data = bytes of {hi,lo} >> 8*addr[1:0] masked to size (lo only if not crossing), rsp_err=0; next state RD_WAIT on new load, else per REQ-011..015, else IDLE.
REQ-013 In RD_WAIT with freeze: state, captured offset/size held, rsp_valid=0; response issued in first unfrozen cycle.
REQ-014 Accepted aligned word store SHALL assert dccm_wren same cycle, wr_addr = req_addr, wr_data = req_wdata; rsp_valid next cycle, rsp_err=0.
REQ-015 Accepted non-crossing sub-word store SHALL register addr/size/wdata, issue dccm_rden with lo=hi=word address, go RMW_RD; next unfrozen cycle go RMW_WR and merge bytes into dccm_rd_data_lo; RMW_WR asserts dccm_wren with merged word; rsp_valid the cycle after write.
REQ-016 Crossing store or size 3 SHALL not access DCCM; rsp_valid next cycle with rsp_err=1, rsp_data=0.
REQ-017 No DCCM strobe SHALL assert while lsu_freeze_dc3=1; RMW_RD/RMW_WR hold under freeze.
REQ-018 dccm_rden and dccm_wren SHALL never be high in the same cycle.
REQ-019 rsp_valid SHALL be a one-cycle pulse per accepted request, in acceptance order.

Reset
REQ-020 While rst_l=0: state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0, dccm_rden=dccm_wren=0, internal registers cleared.
REQ-021 Reset mid-RMW SHALL abandon the operation with no write and no response.

Configuration
REQ-022 Macro RV_DCCM_RMW_EN defined: sub-word stores per REQ-015.
REQ-023 RV_DCCM_RMW_EN undefined: sub-word stores SHALL behave as REQ-016 (rsp_err=1, no access); RMW_RD/RMW_WR unreachable.

Verification
REQ-024 Word store 0x0010 data 0xDEADBEEF, then word load 0x0010 -> wren cycle N, load rsp_data 0xDEADBEEF one cycle after its accept.
REQ-025 Byte store 0xA5 to 0x0013 over word 0x11223344 (RMW_EN) -> rden N, wren N+1 with 0xA5223344, rsp N+2.
REQ-026 Half load at 0x0017 with mem[0x14]=0x44332211, mem[0x18]=0x88776655 -> rd_addr_hi 0x0018, rsp_data 0x00005544.
REQ-027 Word load at 0xFFFE -> rd_addr_hi wraps to 0x0000.
REQ-028 Freeze high 3 cycles in RD_WAIT -> no rsp, req_ready=0, no strobes; rsp in first cycle after freeze drops with correct data.
REQ-029 Word store at 0x0002 -> no wren, rsp_err=1 next cycle; without RV_DCCM_RMW_EN byte store -> rsp_err=1, no access.
